// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and fast-simulation delay constants for rst_seq
package seq_pkg;

    typedef enum logic [2:0] {SNS_HOLD, WAIT_CAL, DRV_WAIT, RUN, FLT} seq_state_t;

    localparam int FAST_SIM_DLY = 8;
    localparam int FAST_SIM_TMO = 64;

endpackage

// File: rtl/seq_dly_cnt.sv
// seq_dly_cnt: delay counter with clear/enable that saturates once it hits its target
module seq_dly_cnt #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             RST_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] target,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;

    assign hit = cnt == target;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !hit)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/rst_seq.sv
// rst_seq: power-up reset sequencer sensor -> controller -> drive; SEQ_FAST_SIM_EN shortens all delays
module rst_seq
    import seq_pkg::*;
#(
    parameter int               CNT_W    = 20,
    parameter logic [CNT_W-1:0] SNS_DLY  = 20'd50000,
    parameter logic [CNT_W-1:0] CAL_TMO  = 20'd1000000,
    parameter logic [CNT_W-1:0] DRV_DLY  = 20'd10000,
    parameter logic [CNT_W-1:0] FLT_HOLD = 20'd100000
) (
    input  logic clk,
    input  logic RST_n,
    input  logic cal_done,
    input  logic fault,
    output logic sns_rst_n,
    output logic ctrl_rst_n,
    output logic drv_en,
    output logic seq_done,
    output logic cal_tmo
);

`ifdef SEQ_FAST_SIM_EN
    localparam logic [CNT_W-1:0] SNS_TGT = CNT_W'(FAST_SIM_DLY - 1);
    localparam logic [CNT_W-1:0] CAL_TGT = CNT_W'(FAST_SIM_TMO - 1);
    localparam logic [CNT_W-1:0] DRV_TGT = CNT_W'(FAST_SIM_DLY - 1);
    localparam logic [CNT_W-1:0] FLT_TGT = CNT_W'(FAST_SIM_DLY - 1);
`else
    localparam logic [CNT_W-1:0] SNS_TGT = SNS_DLY - CNT_W'(1);
    localparam logic [CNT_W-1:0] CAL_TGT = CAL_TMO - CNT_W'(1);
    localparam logic [CNT_W-1:0] DRV_TGT = DRV_DLY - CNT_W'(1);
    localparam logic [CNT_W-1:0] FLT_TGT = FLT_HOLD - CNT_W'(1);
`endif

    seq_state_t       state, state_nxt;
    logic             hit, clr, tmo_hit;
    logic [CNT_W-1:0] target;

    seq_dly_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .RST_n  (RST_n),
        .clr    (clr),
        .en     (state != RUN),
        .target (target),
        .hit    (hit)
    );

    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        target    = state == SNS_HOLD ? SNS_TGT :
                    state == WAIT_CAL ? CAL_TGT :
                    state == DRV_WAIT ? DRV_TGT :
                    state == FLT      ? FLT_TGT : '0;
        if (fault && state != FLT)
            state_nxt = FLT;
        else if (state == SNS_HOLD && hit)
            state_nxt = WAIT_CAL;
        else if (state == WAIT_CAL && cal_done)
            state_nxt = DRV_WAIT;
        else if (state == WAIT_CAL && hit) begin
            state_nxt = FLT;
            tmo_hit   = 1'b1;
        end
        else if (state == DRV_WAIT && hit)
            state_nxt = RUN;
        else if (state == FLT && hit && !fault)
            state_nxt = SNS_HOLD;
        // every transition restarts the delay; RUN keeps it parked at zero
        clr = state_nxt != state || state == RUN;
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state      <= SNS_HOLD;
            sns_rst_n  <= 1'b0;
            ctrl_rst_n <= 1'b0;
            drv_en     <= 1'b0;
            seq_done   <= 1'b0;
            cal_tmo    <= 1'b0;
        end else begin
            state      <= state_nxt;
            sns_rst_n  <= state == WAIT_CAL || state == DRV_WAIT || state == RUN;
            ctrl_rst_n <= state == DRV_WAIT || state == RUN;
            drv_en     <= state == RUN;
            seq_done   <= state == RUN;
            cal_tmo    <= cal_tmo | tmo_hit;
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed checks of rst_seq with SNS_DLY=10, CAL_TMO=30, DRV_DLY=5, FLT_HOLD=20
module tb_rst_seq;

    logic clk = 1'b0;
    logic RST_n = 1'b0;
    logic cal_done = 1'b0;
    logic fault = 1'b0;
    logic sns_rst_n, ctrl_rst_n, drv_en, seq_done, cal_tmo;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    rst_seq #(
        .CNT_W    (20),
        .SNS_DLY  (20'd10),
        .CAL_TMO  (20'd30),
        .DRV_DLY  (20'd5),
        .FLT_HOLD (20'd20)
    ) dut (
        .clk        (clk),
        .RST_n      (RST_n),
        .cal_done   (cal_done),
        .fault      (fault),
        .sns_rst_n  (sns_rst_n),
        .ctrl_rst_n (ctrl_rst_n),
        .drv_en     (drv_en),
        .seq_done   (seq_done),
        .cal_tmo    (cal_tmo)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // leaves RST_n released at a falling edge; the next rising edge is edge 1
    task automatic restart(input logic cal);
        RST_n = 1'b0;
        fault = 1'b0;
        cal_done = cal;
        tick(2);
        RST_n = 1'b1;
    endtask

    task automatic test_reset;
        RST_n = 1'b0;
        tick(3);
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL reset_sns got=%b want=0", sns_rst_n); else pass_cnt++;
        total_cnt++; if (ctrl_rst_n !== 1'b0) $display("FAIL reset_ctrl got=%b want=0", ctrl_rst_n); else pass_cnt++;
        total_cnt++; if (drv_en !== 1'b0) $display("FAIL reset_drv got=%b want=0", drv_en); else pass_cnt++;
        total_cnt++; if (seq_done !== 1'b0) $display("FAIL reset_done got=%b want=0", seq_done); else pass_cnt++;
        total_cnt++; if (cal_tmo !== 1'b0) $display("FAIL reset_tmo got=%b want=0", cal_tmo); else pass_cnt++;
    endtask

    task automatic test_power_up;
        restart(1'b0);
        tick(10);
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL pu_sns_e10 got=%b want=0", sns_rst_n); else pass_cnt++;
        tick(1);
        total_cnt++; if (sns_rst_n !== 1'b1) $display("FAIL pu_sns_e11 got=%b want=1", sns_rst_n); else pass_cnt++;
        tick(20);
        cal_done = 1'b1;
        tick(1);
        total_cnt++; if (ctrl_rst_n !== 1'b0) $display("FAIL pu_ctrl_e32 got=%b want=0", ctrl_rst_n); else pass_cnt++;
        tick(1);
        total_cnt++; if (ctrl_rst_n !== 1'b1) $display("FAIL pu_ctrl_e33 got=%b want=1", ctrl_rst_n); else pass_cnt++;
        tick(4);
        total_cnt++; if (drv_en !== 1'b0) $display("FAIL pu_drv_e37 got=%b want=0", drv_en); else pass_cnt++;
        tick(1);
        total_cnt++; if (drv_en !== 1'b1) $display("FAIL pu_drv_e38 got=%b want=1", drv_en); else pass_cnt++;
        total_cnt++; if (seq_done !== 1'b1) $display("FAIL pu_done_e38 got=%b want=1", seq_done); else pass_cnt++;
        cal_done = 1'b0;
        tick(5);
        total_cnt++; if (drv_en !== 1'b1) $display("FAIL pu_cal_drop_drv got=%b want=1", drv_en); else pass_cnt++;
        total_cnt++; if (cal_tmo !== 1'b0) $display("FAIL pu_tmo got=%b want=0", cal_tmo); else pass_cnt++;
    endtask

    task automatic test_cal_timeout;
        restart(1'b0);
        tick(39);
        total_cnt++; if (cal_tmo !== 1'b0) $display("FAIL tmo_early got=%b want=0", cal_tmo); else pass_cnt++;
        total_cnt++; if (sns_rst_n !== 1'b1) $display("FAIL tmo_sns_e39 got=%b want=1", sns_rst_n); else pass_cnt++;
        tick(2);
        total_cnt++; if (cal_tmo !== 1'b1) $display("FAIL tmo_set got=%b want=1", cal_tmo); else pass_cnt++;
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL tmo_sns_e41 got=%b want=0", sns_rst_n); else pass_cnt++;
        tick(29);
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL tmo_restart_e70 got=%b want=0", sns_rst_n); else pass_cnt++;
        tick(1);
        total_cnt++; if (sns_rst_n !== 1'b1) $display("FAIL tmo_restart_e71 got=%b want=1", sns_rst_n); else pass_cnt++;
        total_cnt++; if (cal_tmo !== 1'b1) $display("FAIL tmo_sticky got=%b want=1", cal_tmo); else pass_cnt++;
    endtask

    task automatic test_fault_run;
        restart(1'b1);
        tick(17);
        total_cnt++; if (drv_en !== 1'b1) $display("FAIL flt_run_drv got=%b want=1", drv_en); else pass_cnt++;
        fault = 1'b1;
        tick(1);
        total_cnt++; if (seq_done !== 1'b1) $display("FAIL flt_done_f0 got=%b want=1", seq_done); else pass_cnt++;
        tick(1);
        total_cnt++; if (drv_en !== 1'b0) $display("FAIL flt_drv_f1 got=%b want=0", drv_en); else pass_cnt++;
        total_cnt++; if (ctrl_rst_n !== 1'b0) $display("FAIL flt_ctrl_f1 got=%b want=0", ctrl_rst_n); else pass_cnt++;
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL flt_sns_f1 got=%b want=0", sns_rst_n); else pass_cnt++;
        total_cnt++; if (seq_done !== 1'b0) $display("FAIL flt_done_f1 got=%b want=0", seq_done); else pass_cnt++;
        tick(1);
        fault = 1'b0;
        tick(28);
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL flt_sns_f30 got=%b want=0", sns_rst_n); else pass_cnt++;
        tick(1);
        total_cnt++; if (sns_rst_n !== 1'b1) $display("FAIL flt_sns_f31 got=%b want=1", sns_rst_n); else pass_cnt++;
        tick(6);
        total_cnt++; if (drv_en !== 1'b1) $display("FAIL flt_rerun_drv got=%b want=1", drv_en); else pass_cnt++;
    endtask

    // runs straight after test_fault_run, entered in RUN with cal_done high
    task automatic test_persistent_fault;
        fault = 1'b1;
        tick(100);
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL pflt_sns_hold got=%b want=0", sns_rst_n); else pass_cnt++;
        total_cnt++; if (drv_en !== 1'b0) $display("FAIL pflt_drv_hold got=%b want=0", drv_en); else pass_cnt++;
        fault = 1'b0;
        tick(11);
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL pflt_sns_g110 got=%b want=0", sns_rst_n); else pass_cnt++;
        tick(1);
        total_cnt++; if (sns_rst_n !== 1'b1) $display("FAIL pflt_sns_g111 got=%b want=1", sns_rst_n); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        restart(1'b1);
        tick(13);
        total_cnt++; if (ctrl_rst_n !== 1'b1) $display("FAIL arst_pre_ctrl got=%b want=1", ctrl_rst_n); else pass_cnt++;
        #2;
        RST_n = 1'b0;
        #1;
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL arst_sns got=%b want=0", sns_rst_n); else pass_cnt++;
        total_cnt++; if (ctrl_rst_n !== 1'b0) $display("FAIL arst_ctrl got=%b want=0", ctrl_rst_n); else pass_cnt++;
        total_cnt++; if (drv_en !== 1'b0) $display("FAIL arst_drv got=%b want=0", drv_en); else pass_cnt++;
        @(negedge clk);
        RST_n = 1'b1;
        tick(10);
        total_cnt++; if (sns_rst_n !== 1'b0) $display("FAIL arst_restart_e10 got=%b want=0", sns_rst_n); else pass_cnt++;
        tick(1);
        total_cnt++; if (sns_rst_n !== 1'b1) $display("FAIL arst_restart_e11 got=%b want=1", sns_rst_n); else pass_cnt++;
    endtask

    task automatic test_same_clk_priority;
        restart(1'b0);
        tick(39);
        cal_done = 1'b1;
        tick(1);
        total_cnt++; if (cal_tmo !== 1'b0) $display("FAIL prio_tmo_e40 got=%b want=0", cal_tmo); else pass_cnt++;
        tick(1);
        total_cnt++; if (ctrl_rst_n !== 1'b1) $display("FAIL prio_ctrl_e41 got=%b want=1", ctrl_rst_n); else pass_cnt++;
        total_cnt++; if (sns_rst_n !== 1'b1) $display("FAIL prio_sns_e41 got=%b want=1", sns_rst_n); else pass_cnt++;
        total_cnt++; if (cal_tmo !== 1'b0) $display("FAIL prio_tmo_e41 got=%b want=0", cal_tmo); else pass_cnt++;
        tick(5);
        total_cnt++; if (drv_en !== 1'b1) $display("FAIL prio_drv_e46 got=%b want=1", drv_en); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_cal_timeout();
        test_fault_run();
        test_persistent_fault();
        test_async_reset();
        test_same_clk_priority();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
